fir_filter: RTL and testbench
=============================

// Module: fir_filter
// PURPOSE
//  Parameterised, fully parallel, pipelined signed FIR filter with one output per accepted input sample.
//  Filter coefficients are compile-time constants.
//  Optional symmetric/antisymmetric pre-adder folding and configurable register insertion.
//  Sits in a streaming DSP datapath; samples are qualified by valid_in and need not arrive every cycle.
// PARAMETERS
//  INPUT_WIDTH        16        din width, signed two's complement
//  COEFF_WIDTH        16        coefficient width, signed
//  OUTPUT_WIDTH       20        dout width
//  OUTPUT_WIDTH_FULL  20        full-precision width; must equal $clog2(sum|COEFFS[i]|)+INPUT_WIDTH
//  SYMMETRY           1         0 = none; 1 = symmetric (c[i]=c[N-1-i]); 2 = antisymmetric (c[i]=-c[N-1-i])
//  NUM_TAPS           5         number of taps N, >=1
//  COEFFS             '{1,2,3,2,1}  logic [COEFF_WIDTH-1:0] [0:N-1]; COEFFS[0] multiplies the newest sample
//  PIPELINE_MUL       1         1 = register after each multiplier
//  PIPELINE_PREADD    1         1 = register after each pre-adder (ignored when SYMMETRY=0)
//  PIPELINE_ADD_RATIO 1         adder tree: register after every RATIO-th level; 0 = combinational tree
//  OUTPUT_REG         1         1 = register dout/valid_out
// PORTS
//  clk        in   1                  clock; all state changes on its rising edge
//  rst        in   1                  reset, asynchronous, active-low
//  valid_in   in   1                  din is a valid sample this cycle
//  din        in   INPUT_WIDTH        input sample, signed
//  valid_out  out  1                  dout holds a valid result this cycle
//  dout       out  OUTPUT_WIDTH       filtered output, signed
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset: delay line, every pipeline register, valid pipe, valid_out and dout are cleared to 0 immediately.
//  - Reset mid-stream: in-flight results are discarded (no valid_out for them).
//    Filtering restarts from an all-zero history after reset is released.
//  - Delay line x[0..N-1] shifts only on valid_in=1 (x[0]<=din); it holds otherwise.
//  - y[n] = sum_{i=0..N-1} signed(COEFFS[i]) * x[n-i].
//    Computed exactly in OUTPUT_WIDTH_FULL bits; overflow is impossible by construction.
//  - SYMMETRY=1: M=ceil(N/2) products of (x[i]+x[N-1-i])*c[i]. For odd N, the middle tap is not pre-added.
//  - SYMMETRY=2: M=floor(N/2) products of (x[i]-x[N-1-i])*c[i]. For odd N, the middle tap is not pre-added.
//  - SYMMETRY=0: M=N products. Pre-adder outputs are INPUT_WIDTH+1 bits.
//  - Adder tree: D=ceil(log2 M) levels; R=floor(D/RATIO) register stages (R=0 if RATIO=0).
//  - Latency L = 1 (delay line) + PIPELINE_PREADD*(SYMMETRY!=0) + PIPELINE_MUL + R + OUTPUT_REG cycles,
//    from the valid_in edge to the valid_out edge. Default configuration: L=6.
//  - The datapath pipeline advances every cycle regardless of valid_in.
//  - valid_in is delayed through a matching L-deep valid shift register, so valid_out mirrors the input
//    pattern, gaps included: exactly one valid_out per valid_in, in order.
//  - No backpressure; a new sample is accepted every cycle.
//  - Width conversion:
//      OUTPUT_WIDTH<OUTPUT_WIDTH_FULL: dout = full[FULL-1 -: OUTPUT_WIDTH]; arithmetic truncation of LSBs, no rounding.
//      OUTPUT_WIDTH>=OUTPUT_WIDTH_FULL: dout = sign-extended full result.
//  - When valid_out=0, dout holds its last value; the bench must not check it then.
//  - Illegal parameters are elaborated with $error:
//      FULL mismatch; SYMMETRY not in {0,1,2}; COEFFS not matching the declared symmetry.
// TESTING
//  1 Impulse: defaults, din=1 then 7 zeros, all valid -> dout = 1,2,3,2,1,0,0,0; first valid_out at input cycle+6.
//  2 Extreme: din=-32768 single sample -> dout = -32768,-65536,-98304,-65536,-32768.
//    Then din=32767 held for 5 samples -> dout settles at 294903.
//  3 Gapped input: impulse with valid_in toggling 1,0,0,1,0,1,...
//    -> same output values as scenario 1; valid_out pattern equals the valid_in pattern delayed 6 cycles.
//  4 Reset mid-stream: assert rst (low) 2 cycles into the impulse response -> valid_out/dout=0 at once.
//    A later impulse gives a clean 1,2,3,2,1.
//  5 Configuration sweep: SYMMETRY 0/1, every PIPELINE_* combination, OUTPUT_REG 0/1, random din vs a software model.
//    Values must be bit-exact; only latency differs, and it equals L.
//  6 Truncation: OUTPUT_WIDTH=16, FULL=20, input 32767 held -> dout = 294903>>>4 = 18431.
//    Input -1 held -> dout = -9>>>4 = -1.

Source files
------------

// File: rtl/fir_filter.sv
// Pipelined, fully parallel signed FIR with compile-time coefficients, optional
// symmetric/antisymmetric pre-add folding and configurable register insertion.
module fir_filter #(
  parameter int INPUT_WIDTH        = 16,
  parameter int COEFF_WIDTH        = 16,
  parameter int OUTPUT_WIDTH       = 20,
  parameter int OUTPUT_WIDTH_FULL  = 20,
  parameter int SYMMETRY           = 1,
  parameter int NUM_TAPS           = 5,
  parameter logic [0:NUM_TAPS-1][COEFF_WIDTH-1:0] COEFFS = {16'd1, 16'd2, 16'd3, 16'd2, 16'd1},
  parameter int PIPELINE_MUL       = 1,
  parameter int PIPELINE_PREADD    = 1,
  parameter int PIPELINE_ADD_RATIO = 1,
  parameter int OUTPUT_REG         = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  input  logic signed [INPUT_WIDTH-1:0]  din,
  output logic                           valid_out,
  output logic signed [OUTPUT_WIDTH-1:0] dout
);

  localparam int IW  = INPUT_WIDTH;
  localparam int PW  = INPUT_WIDTH + 1;
  localparam int FW  = OUTPUT_WIDTH_FULL;
  localparam int OW  = OUTPUT_WIDTH;
  localparam int N   = NUM_TAPS;
  localparam int M0  = (SYMMETRY == 0) ? N : (SYMMETRY == 1) ? (N + 1) / 2 : N / 2;
  localparam int M   = (M0 < 1) ? 1 : M0;
  localparam int D   = $clog2(M);
  localparam int RT  = (PIPELINE_ADD_RATIO == 0) ? 1 : PIPELINE_ADD_RATIO;
  localparam int R   = (PIPELINE_ADD_RATIO == 0) ? 0 : D / RT;
  localparam bit PA_REG = (SYMMETRY != 0) && (PIPELINE_PREADD != 0);
  localparam int L   = 1 + (PA_REG ? 1 : 0) + ((PIPELINE_MUL != 0) ? 1 : 0) + R
                       + ((OUTPUT_REG != 0) ? 1 : 0);
  localparam int VP  = L - ((OUTPUT_REG != 0) ? 1 : 0);
  localparam int SH  = (OW < FW) ? FW - OW : 0;

  function automatic int coef(input int i);
    return int'($signed(COEFFS[i]));
  endfunction

  function automatic int abs_sum();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += (coef(i) < 0) ? -coef(i) : coef(i);
    return s;
  endfunction

  function automatic bit coeffs_match();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (SYMMETRY == 1 && coef(i) != coef(N - 1 - i)) ok = 1'b0;
      if (SYMMETRY == 2 && coef(i) != -coef(N - 1 - i)) ok = 1'b0;
    end
    return ok;
  endfunction

  if (FW != $clog2(abs_sum()) + IW) begin : g_err_full
    $error("fir_filter: OUTPUT_WIDTH_FULL does not match coefficient magnitude");
  end
  if (SYMMETRY < 0 || SYMMETRY > 2) begin : g_err_sym
    $error("fir_filter: SYMMETRY must be 0, 1 or 2");
  end
  if (!coeffs_match() || M0 < 1) begin : g_err_coef
    $error("fir_filter: COEFFS do not match the declared symmetry");
  end

  // Delay line: shifts only on accepted samples.
  logic signed [IW-1:0] x_d [N];
  logic signed [IW-1:0] x_q [N];

  always_comb begin
    x_d = x_q;
    if (valid_in) begin
      x_d[0] = din;
      for (int i = 1; i < N; i++) x_d[i] = x_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) x_q[i] <= '0;
    end else begin
      x_q <= x_d;
    end
  end

  // Pre-adder: the middle tap of an odd-length folded filter passes through alone.
  logic signed [PW-1:0] pa_d [M];
  logic signed [PW-1:0] pa   [M];

  always_comb begin
    for (int i = 0; i < M; i++) begin
      if (SYMMETRY == 0 || i == N - 1 - i) pa_d[i] = PW'(x_q[i]);
      else if (SYMMETRY == 1)              pa_d[i] = PW'(x_q[i]) + PW'(x_q[N-1-i]);
      else                                 pa_d[i] = PW'(x_q[i]) - PW'(x_q[N-1-i]);
    end
  end

  if (PA_REG) begin : g_pa_reg
    logic signed [PW-1:0] pa_q [M];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < M; i++) pa_q[i] <= '0;
      end else begin
        pa_q <= pa_d;
      end
    end
    assign pa = pa_q;
  end else begin : g_pa_comb
    assign pa = pa_d;
  end

  // Products fit FW bits because their magnitude is bounded by sum|c| * 2^(IW-1).
  logic signed [FW-1:0] prod_d [M];
  logic signed [FW-1:0] prod   [M];

  always_comb begin
    for (int i = 0; i < M; i++) prod_d[i] = FW'(pa[i]) * FW'($signed(COEFFS[i]));
  end

  if (PIPELINE_MUL != 0) begin : g_mul_reg
    logic signed [FW-1:0] prod_q [M];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < M; i++) prod_q[i] <= '0;
      end else begin
        prod_q <= prod_d;
      end
    end
    assign prod = prod_q;
  end else begin : g_mul_comb
    assign prod = prod_d;
  end

  // Binary adder tree; level l holds ceil(M / 2^l) partial sums.
  for (genvar l = 0; l <= D; l++) begin : g_lvl
    localparam int NL = (M + (1 << l) - 1) >> l;
    logic signed [FW-1:0] node [NL];
    if (l == 0) begin : g_leaf
      assign node = prod;
    end else begin : g_sum
      localparam int NP = (M + (1 << (l - 1)) - 1) >> (l - 1);
      logic signed [FW-1:0] node_d [NL];
      for (genvar j = 0; j < NL; j++) begin : g_node
        if (2 * j + 1 < NP) begin : g_pair
          assign node_d[j] = g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
        end else begin : g_pass
          assign node_d[j] = g_lvl[l-1].node[2*j];
        end
      end
      if (PIPELINE_ADD_RATIO != 0 && (l % RT) == 0) begin : g_reg
        logic signed [FW-1:0] node_q [NL];
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            for (int j = 0; j < NL; j++) node_q[j] <= '0;
          end else begin
            node_q <= node_d;
          end
        end
        assign node = node_q;
      end else begin : g_comb
        assign node = node_d;
      end
    end
  end

  // Arithmetic shift drops LSBs when narrowing; the cast sign-extends when widening.
  logic signed [FW-1:0] full;
  logic signed [OW-1:0] dout_cvt;
  assign full     = g_lvl[D].node[0];
  assign dout_cvt = OW'(full >>> SH);

  logic [VP-1:0] vpipe_d;
  logic [VP-1:0] vpipe_q;

  always_comb begin
    vpipe_d[0] = valid_in;
    for (int k = 1; k < VP; k++) vpipe_d[k] = vpipe_q[k-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vpipe_q <= '0;
    else      vpipe_q <= vpipe_d;
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic                 valid_out_q;
    logic signed [OW-1:0] dout_d;
    logic signed [OW-1:0] dout_q;
    assign dout_d = vpipe_q[VP-1] ? dout_cvt : dout_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_out_q <= 1'b0;
        dout_q      <= '0;
      end else begin
        valid_out_q <= vpipe_q[VP-1];
        dout_q      <= dout_d;
      end
    end
    assign valid_out = valid_out_q;
    assign dout      = dout_q;
  end else begin : g_out_comb
    assign valid_out = vpipe_q[VP-1];
    assign dout      = dout_cvt;
  end

endmodule

// File: tb/tb_fir_filter.sv
// Bench for fir_filter: three configurations driven by one stimulus stream and
// checked against a convolution model with per-instance expected queues.
module tb_fir_filter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid_in = 1'b0;
  logic signed [15:0] din = '0;

  logic vo0, vo1, vo2;
  logic signed [19:0] dout0;
  logic signed [15:0] dout1;
  logic signed [21:0] dout2;

  always #5 clk = ~clk;

  // dut0: defaults, L=6. dut1: unfolded, combinational, truncated to 16 bits, L=1.
  // dut2: antisymmetric, pre-add and tree registered, sign-extended to 22 bits, L=4.
  fir_filter dut0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .valid_out(vo0), .dout(dout0)
  );

  fir_filter #(
    .OUTPUT_WIDTH(16), .SYMMETRY(0), .PIPELINE_MUL(0), .PIPELINE_PREADD(1),
    .PIPELINE_ADD_RATIO(0), .OUTPUT_REG(0)
  ) dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .valid_out(vo1), .dout(dout1)
  );

  fir_filter #(
    .OUTPUT_WIDTH(22), .OUTPUT_WIDTH_FULL(19), .SYMMETRY(2),
    .COEFFS({16'sd1, 16'sd2, 16'sd0, -16'sd2, -16'sd1}),
    .PIPELINE_MUL(0), .PIPELINE_PREADD(1), .PIPELINE_ADD_RATIO(1), .OUTPUT_REG(1)
  ) dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .valid_out(vo2), .dout(dout2)
  );

  localparam int LAT [3] = '{6, 1, 4};
  localparam int C_SYM [5] = '{1, 2, 3, 2, 1};
  localparam int C_ANTI [5] = '{1, 2, 0, -2, -1};

  typedef struct {
    int     due;
    longint val;
  } exp_t;

  exp_t   exp_q [3][$];
  longint hist [5];
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: y[n] = sum c[i] * x[n-i] over accepted samples only.
  always @(posedge clk) begin
    if (rst) begin
      longint y_sym;
      longint y_anti;
      cyc++;
      if (valid_in) begin
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = longint'(din);
        y_sym  = 0;
        y_anti = 0;
        for (int i = 0; i < 5; i++) begin
          y_sym  += C_SYM[i] * hist[i];
          y_anti += C_ANTI[i] * hist[i];
        end
        exp_q[0].push_back('{cyc + LAT[0] - 1, y_sym});
        exp_q[1].push_back('{cyc + LAT[1] - 1, y_sym >>> 4});
        exp_q[2].push_back('{cyc + LAT[2] - 1, y_anti});
      end
    end
  end

  task automatic check_dut(input int k, input logic vo, input longint got);
    logic due_now;
    due_now = (exp_q[k].size() > 0) && (exp_q[k][0].due == cyc);
    check($sformatf("dut%0d_valid_out", k), longint'(vo), longint'(due_now));
    if (due_now) begin
      if (vo) check($sformatf("dut%0d_dout", k), got, exp_q[k][0].val);
      void'(exp_q[k].pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check_dut(0, vo0, longint'(dout0));
      check_dut(1, vo1, longint'(dout1));
      check_dut(2, vo2, longint'(dout2));
    end
  end

  task automatic drive(input logic v, input int d);
    @(posedge clk);
    #1;
    valid_in = v;
    din      = 16'(d);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_vo0"}, longint'(vo0), 0);
    check({tag, "_dout0"}, longint'(dout0), 0);
    check({tag, "_vo1"}, longint'(vo1), 0);
    check({tag, "_dout1"}, longint'(dout1), 0);
    check({tag, "_vo2"}, longint'(vo2), 0);
    check({tag, "_dout2"}, longint'(dout2), 0);
  endtask

  // Reset lands mid-cycle so the asynchronous clear is observed before any edge.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst      = 1'b0;
    valid_in = 1'b0;
    din      = '0;
    #1;
    check_zero_outputs("async_reset");
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    for (int i = 0; i < 5; i++) hist[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic hold_and_check(input int d, input longint e0, input longint e1);
    repeat (12) drive(1'b1, d);
    @(negedge clk);
    check("steady_vo0", longint'(vo0), 1);
    check("steady_dout0", longint'(dout0), e0);
    check("steady_dout1", longint'(dout1), e1);
    check("steady_dout2", longint'(dout2), 0);
  endtask

  initial begin
    int pat [10];
    int first;
    pat = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1};
    for (int i = 0; i < 5; i++) hist[i] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Impulse, all valid.
    drive(1'b1, 1);
    repeat (7) drive(1'b1, 0);
    repeat (8) drive(1'b0, 0);

    // Extremes: single most-negative sample, then held full-scale values.
    drive(1'b1, -32768);
    repeat (5) drive(1'b1, 0);
    hold_and_check(32767, 294903, 18431);
    hold_and_check(-1, -9, -1);
    repeat (8) drive(1'b1, 0);
    repeat (8) drive(1'b0, 0);

    // Gapped impulse: the valid pattern must reappear at each output.
    first = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        drive(pat[i] != 0, (pat[i] != 0 && first != 0) ? 1 : 0);
        if (pat[i] != 0) first = 0;
      end
    end
    repeat (8) drive(1'b0, 0);

    // Reset two cycles into the impulse response, then a clean impulse.
    drive(1'b1, 1);
    repeat (6) drive(1'b1, 0);
    pulse_reset();
    drive(1'b1, 1);
    repeat (7) drive(1'b1, 0);
    repeat (8) drive(1'b0, 0);

    // Random samples with random gaps, extremes mixed in.
    for (int i = 0; i < 400; i++) begin
      int sel;
      int d;
      sel = int'($urandom_range(0, 7));
      d   = (sel == 0) ? -32768 : (sel == 1) ? 32767 : int'($urandom_range(0, 65535)) - 32768;
      drive($urandom_range(0, 3) != 0, d);
    end
    repeat (10) drive(1'b0, 0);

    @(negedge clk);
    check("drain_q0", longint'(exp_q[0].size()), 0);
    check("drain_q1", longint'(exp_q[1].size()), 0);
    check("drain_q2", longint'(exp_q[2].size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
